// File: rtl/vcve2_vec_alu_seq.sv
// Sequential vector ALU: processes one 32-bit beat per cycle over a VLEN-bit operand, tail-undisturbed.
// Optional multiplier (op 9) enabled by defining VCVE2_VEC_MUL_EN.
module vcve2_vec_alu_seq #(
  parameter int VLEN = 128
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic [3:0]                     op_i,
  input  logic [2:0]                     vsew_i,
  input  logic                           vx_sel_i,
  input  logic [$clog2(VLEN/8):0]        vl_i,
  input  logic [VLEN-1:0]                vs1_i,
  input  logic [VLEN-1:0]                vs2_i,
  input  logic [VLEN-1:0]                vd_old_i,
  input  logic [31:0]                    rs1_i,
  input  logic                           kill_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [VLEN-1:0]                result_o,
  output logic                           illegal_o,
  output logic                           busy_o
);

  localparam int NBEATS = VLEN / 32;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int VLW    = $clog2(VLEN/8) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state;
  logic [BW-1:0]   beat;
  logic [3:0]      op_r;
  logic [1:0]      sew_r;
  logic [VLW-1:0]  vl_r;
  logic [VLEN-1:0] vs1_r, vs2_r, vd_r;
  logic [VLEN-1:0] result_r;
  logic            illegal_r;

  logic            illegal_req;
  logic [VLEN-1:0] vs1_sel;
  logic [VLW-1:0]  nelem;
  logic [VLW-1:0]  vl_clamp;

  always_comb begin
    illegal_req = (op_i > 4'd9) || (vsew_i > 3'd2);
`ifndef VCVE2_VEC_MUL_EN
    if (op_i == 4'd9) illegal_req = 1'b1;
`endif
  end

  always_comb begin
    vs1_sel = vs1_i;
    if (vx_sel_i) begin
      case (vsew_i)
        3'd0:    vs1_sel = {(VLEN/8){rs1_i[7:0]}};
        3'd1:    vs1_sel = {(VLEN/16){rs1_i[15:0]}};
        default: vs1_sel = {NBEATS{rs1_i}};
      endcase
    end
  end

  // vl is clamped once at capture so the beat logic only needs one compare
  assign nelem    = VLW'(VLEN/8) >> vsew_i[1:0];
  assign vl_clamp = (vl_i > nelem) ? nelem : vl_i;

  function automatic logic [31:0] elem_op(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [1:0] sew);
    logic signed [31:0] sa, sb;
    logic [31:0]        r;
    case (sew)
      2'd0:    begin sa = {{24{a[7]}},  a[7:0]};  sb = {{24{b[7]}},  b[7:0]};  end
      2'd1:    begin sa = {{16{a[15]}}, a[15:0]}; sb = {{16{b[15]}}, b[15:0]}; end
      default: begin sa = a;                      sb = b;                      end
    endcase
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = (a < b) ? a : b;
      4'd6:    r = (sa < sb) ? a : b;
      4'd7:    r = (a > b) ? a : b;
      4'd8:    r = (sa > sb) ? a : b;
`ifdef VCVE2_VEC_MUL_EN
      4'd9:    r = a * b;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [31:0]    a_w, b_w, d_w, beat_res, tmp;
  logic [VLW-1:0] idx;

  assign a_w = vs2_r[32*beat +: 32];
  assign b_w = vs1_r[32*beat +: 32];
  assign d_w = vd_r[32*beat +: 32];

  // operands are zero-extended into elem_op; only the low SEW bits are kept
  always_comb begin
    beat_res = d_w;
    tmp      = '0;
    idx      = '0;
    case (sew_r)
      2'd0: begin
        for (int k = 0; k < 4; k++) begin
          idx = (VLW'(beat) << 2) + VLW'(k);
          tmp = elem_op(op_r, {24'd0, a_w[8*k +: 8]}, {24'd0, b_w[8*k +: 8]}, 2'd0);
          if (idx < vl_r) beat_res[8*k +: 8] = tmp[7:0];
        end
      end
      2'd1: begin
        for (int k = 0; k < 2; k++) begin
          idx = (VLW'(beat) << 1) + VLW'(k);
          tmp = elem_op(op_r, {16'd0, a_w[16*k +: 16]}, {16'd0, b_w[16*k +: 16]}, 2'd1);
          if (idx < vl_r) beat_res[16*k +: 16] = tmp[15:0];
        end
      end
      default: begin
        idx = VLW'(beat);
        tmp = elem_op(op_r, a_w, b_w, 2'd2);
        if (idx < vl_r) beat_res = tmp;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      beat      <= '0;
      result_r  <= '0;
      illegal_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (valid_i) begin
            op_r      <= op_i;
            sew_r     <= vsew_i[1:0];
            vl_r      <= vl_clamp;
            vs1_r     <= vs1_sel;
            vs2_r     <= vs2_i;
            vd_r      <= vd_old_i;
            result_r  <= vd_old_i;
            illegal_r <= illegal_req;
            beat      <= '0;
            state     <= illegal_req ? S_DONE : S_BUSY;
          end
        end
        S_BUSY: begin
          if (kill_i) begin
            state <= S_IDLE;
            beat  <= '0;
          end else begin
            result_r[32*beat +: 32] <= beat_res;
            if (beat == BW'(NBEATS-1)) begin
              beat  <= '0;
              state <= S_DONE;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (kill_i || ready_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ready_o   = (state == S_IDLE);
  assign busy_o    = (state != S_IDLE);
  assign valid_o   = (state == S_DONE);
  assign result_o  = result_r;
  assign illegal_o = illegal_r;

endmodule

// File: tb/tb_vcve2_vec_alu_seq.sv
// Scoreboard bench for vcve2_vec_alu_seq: reference model predicts result, illegal flag and latency.
module tb_vcve2_vec_alu_seq;
  localparam int VLEN   = 128;
  localparam int NBEATS = VLEN / 32;
  localparam int VLW    = $clog2(VLEN/8) + 1;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            valid_i = 1'b0;
  logic            ready_o;
  logic [3:0]      op_i = '0;
  logic [2:0]      vsew_i = '0;
  logic            vx_sel_i = 1'b0;
  logic [VLW-1:0]  vl_i = '0;
  logic [VLEN-1:0] vs1_i = '0, vs2_i = '0, vd_old_i = '0;
  logic [31:0]     rs1_i = '0;
  logic            kill_i = 1'b0;
  logic            valid_o;
  logic            ready_i = 1'b0;
  logic [VLEN-1:0] result_o;
  logic            illegal_o;
  logic            busy_o;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [VLEN-1:0] res;
    logic            ill;
    int              lat;
  } exp_t;
  exp_t exp_q[$];

  vcve2_vec_alu_seq #(.VLEN(VLEN)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .vsew_i(vsew_i), .vx_sel_i(vx_sel_i), .vl_i(vl_i),
    .vs1_i(vs1_i), .vs2_i(vs2_i), .vd_old_i(vd_old_i), .rs1_i(rs1_i),
    .kill_i(kill_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .illegal_o(illegal_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [VLEN-1:0] rnd_vec();
    logic [VLEN-1:0] v;
    for (int i = 0; i < NBEATS; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [VLEN-1:0] model(input logic [3:0] op, input logic [2:0] sew,
      input logic vx, input int vl, input logic [VLEN-1:0] v1, input logic [VLEN-1:0] v2,
      input logic [VLEN-1:0] vd, input logic [31:0] rs, output logic ill);
    int w, n, vle;
    logic [63:0] mask, a, b, r;
    logic signed [63:0] sa, sb;
    logic [VLEN-1:0] out, m;
    ill = (sew > 3'd2) || (op > 4'd9);
`ifndef VCVE2_VEC_MUL_EN
    if (op == 4'd9) ill = 1'b1;
`endif
    out = vd;
    if (ill) return out;
    w    = 8 << sew;
    n    = VLEN / w;
    vle  = (vl < n) ? vl : n;
    mask = (64'd1 << w) - 64'd1;
    for (int i = 0; i < vle; i++) begin
      a  = 64'(v2 >> (i*w)) & mask;
      b  = vx ? (64'(rs) & mask) : (64'(v1 >> (i*w)) & mask);
      sa = a[w-1] ? $signed(a - (64'd1 << w)) : $signed(a);
      sb = b[w-1] ? $signed(b - (64'd1 << w)) : $signed(b);
      case (op)
        4'd0: r = a + b;
        4'd1: r = a - b;
        4'd2: r = a & b;
        4'd3: r = a | b;
        4'd4: r = a ^ b;
        4'd5: r = (a < b) ? a : b;
        4'd6: r = (sa < sb) ? a : b;
        4'd7: r = (a > b) ? a : b;
        4'd8: r = (sa > sb) ? a : b;
        4'd9: r = a * b;
        default: r = 64'd0;
      endcase
      m   = VLEN'(mask) << (i*w);
      out = (out & ~m) | (VLEN'(r & mask) << (i*w));
    end
    return out;
  endfunction

  // Drives one accept, pushes its prediction, scrambles inputs, waits for valid_o (bounded).
  task automatic run_op(input logic [3:0] op, input logic [2:0] sew, input logic vx,
      input int vl, input logic [VLEN-1:0] v1, input logic [VLEN-1:0] v2,
      input logic [VLEN-1:0] vd, input logic [31:0] rs,
      output logic [VLEN-1:0] res, output logic ill, output int lat);
    exp_t e;
    logic eill;
    e.res = model(op, sew, vx, vl, v1, v2, vd, rs, eill);
    e.ill = eill;
    e.lat = eill ? 1 : NBEATS + 1;
    exp_q.push_back(e);
    op_i = op; vsew_i = sew; vx_sel_i = vx; vl_i = VLW'(vl);
    vs1_i = v1; vs2_i = v2; vd_old_i = vd; rs1_i = rs;
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    op_i = 4'($urandom); vsew_i = 3'($urandom); vx_sel_i = ~vx; vl_i = VLW'($urandom);
    vs1_i = rnd_vec(); vs2_i = rnd_vec(); vd_old_i = rnd_vec(); rs1_i = $urandom;
    lat = 1;
    while (!valid_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result_o;
    ill = illegal_o;
  endtask

  task automatic consume();
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; valid_i = 1'b1; kill_i = 1'b1; vd_old_i = rnd_vec();
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0; valid_i = 1'b0; kill_i = 1'b0;
    tests++; if (result_o !== '0) begin fails++; $display("FAIL reset_result got=%h want=0", result_o); end
    tests++; if ({valid_o, illegal_o, ready_o, busy_o} !== 4'b0010) begin
      fails++; $display("FAIL reset_flags got v/i/r/b=%b want=0010", {valid_o, illegal_o, ready_o, busy_o});
    end
  endtask

  task automatic check_op(input string name, input logic [3:0] op, input logic [2:0] sew,
      input logic vx, input int vl, input logic [VLEN-1:0] v1, input logic [VLEN-1:0] v2,
      input logic [VLEN-1:0] vd, input logic [31:0] rs, input logic [VLEN-1:0] want);
    logic [VLEN-1:0] res; logic ill; int lat; exp_t e;
    run_op(op, sew, vx, vl, v1, v2, vd, rs, res, ill, lat);
    e = exp_q.pop_front();
    tests++; if (res !== want || res !== e.res) begin
      fails++; $display("FAIL %s_result got=%h want=%h", name, res, want);
    end
    tests++; if (ill !== e.ill || lat !== e.lat) begin
      fails++; $display("FAIL %s_timing got ill=%b lat=%0d want ill=%b lat=%0d", name, ill, lat, e.ill, e.lat);
    end
    consume();
  endtask

  task automatic test_directed();
    logic [VLEN-1:0] vd, w;
    check_op("add_wrap", 4'd0, 3'd0, 1'b0, 16, {(VLEN/8){8'h01}}, {(VLEN/8){8'hFF}},
             rnd_vec(), 32'd0, '0);
    vd = {(VLEN/16){16'hAAAA}};
    w  = vd; w[47:0] = {3{16'hFFFE}};
    check_op("sub_tail", 4'd1, 3'd1, 1'b0, 3, {(VLEN/16){16'd7}}, {(VLEN/16){16'd5}},
             vd, 32'd0, w);
    check_op("min_vx", 4'd6, 3'd2, 1'b1, 4, rnd_vec(), {NBEATS{32'd1}}, rnd_vec(),
             32'hFFFF_FFFF, {NBEATS{32'hFFFF_FFFF}});
    check_op("minu_vx", 4'd5, 3'd2, 1'b1, 4, rnd_vec(), {NBEATS{32'd1}}, rnd_vec(),
             32'hFFFF_FFFF, {NBEATS{32'd1}});
    vd = rnd_vec();
    check_op("vl_zero", 4'd0, 3'd0, 1'b0, 0, rnd_vec(), rnd_vec(), vd, 32'd0, vd);
    vd = rnd_vec();
    check_op("bad_sew", 4'd0, 3'd3, 1'b0, 16, rnd_vec(), rnd_vec(), vd, 32'd0, vd);
    vd = rnd_vec();
    check_op("bad_op", 4'd12, 3'd0, 1'b0, 16, rnd_vec(), rnd_vec(), vd, 32'd0, vd);
    vd = {(VLEN/8){8'h5A}};
    w  = vd; w[63:0] = {8{8'h06}};
`ifndef VCVE2_VEC_MUL_EN
    w  = vd;
`endif
    check_op("mul_op9", 4'd9, 3'd0, 1'b1, 8, rnd_vec(), {(VLEN/8){8'h03}}, vd, 32'd2, w);
    vd = {NBEATS{32'h1234_5678}};
    w  = vd; w[VLEN-1:96] = 32'h8000_0000;
    w[95:0] = {32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    check_op("max_clamp", 4'd8, 3'd2, 1'b1, 16, rnd_vec(), {NBEATS{32'h8000_0000}}, vd,
             32'h8000_0000, w);
  endtask

  task automatic test_backpressure();
    logic [VLEN-1:0] res, held; logic ill; int lat; exp_t e;
    run_op(4'd4, 3'd0, 1'b0, 11, rnd_vec(), rnd_vec(), rnd_vec(), 32'd0, res, ill, lat);
    e = exp_q.pop_front();
    tests++; if (res !== e.res || lat !== e.lat) begin
      fails++; $display("FAIL bp_result got=%h lat=%0d want=%h lat=%0d", res, lat, e.res, e.lat);
    end
    held = result_o;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      tests++; if (valid_o !== 1'b1 || result_o !== held) begin
        fails++; $display("FAIL bp_hold%0d got valid=%b res=%h want valid=1 res=%h", c, valid_o, result_o, held);
      end
    end
    consume();
    tests++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      fails++; $display("FAIL bp_release got valid=%b ready=%b want 0/1", valid_o, ready_o);
    end
  endtask

  task automatic test_kill_reset();
    int seen;
    logic [VLEN-1:0] res; logic ill; int lat; exp_t e;
    op_i = 4'd0; vsew_i = 3'd0; vl_i = VLW'(16); vx_sel_i = 1'b0;
    vs1_i = rnd_vec(); vs2_i = rnd_vec(); vd_old_i = rnd_vec();
    valid_i = 1'b1; kill_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL kill_idle got busy=%b want=1", busy_o); end
    @(posedge clk); #1;
    kill_i = 1'b0;
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL kill_busy0 got busy=%b want=0", busy_o); end
    valid_i = 1'b1; vd_old_i = {NBEATS{32'hDEAD_BEEF}};
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    kill_i = 1'b1;
    @(posedge clk); #1;
    kill_i = 1'b0;
    tests++; if ({busy_o, valid_o, ready_o} !== 3'b001) begin
      fails++; $display("FAIL kill_beat2 got b/v/r=%b want=001", {busy_o, valid_o, ready_o});
    end
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (valid_o) seen++; end
    tests++; if (seen !== 0) begin fails++; $display("FAIL kill_novalid got=%0d want=0", seen); end
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b1; kill_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0; kill_i = 1'b0;
    tests++; if (result_o !== '0 || {busy_o, valid_o, illegal_o, ready_o} !== 4'b0001) begin
      fails++; $display("FAIL rst_busy got res=%h b/v/i/r=%b want res=0 0001", result_o, {busy_o, valid_o, illegal_o, ready_o});
    end
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (valid_o) seen++; end
    tests++; if (seen !== 0) begin fails++; $display("FAIL rst_novalid got=%0d want=0", seen); end
    run_op(4'd3, 3'd1, 1'b0, 5, rnd_vec(), rnd_vec(), rnd_vec(), 32'd0, res, ill, lat);
    e = exp_q.pop_front();
    tests++; if (res !== e.res) begin fails++; $display("FAIL killdone_result got=%h want=%h", res, e.res); end
    kill_i = 1'b1; ready_i = 1'b1;
    @(posedge clk); #1;
    kill_i = 1'b0; ready_i = 1'b0;
    tests++; if ({valid_o, ready_o} !== 2'b01) begin
      fails++; $display("FAIL kill_ready_done got v/r=%b want=01", {valid_o, ready_o});
    end
  endtask

  task automatic test_back_to_back();
    logic [VLEN-1:0] res; logic ill; int lat; exp_t e;
    logic [3:0] op; logic [2:0] sew;
    for (int t = 0; t < 12; t++) begin
      op  = 4'($urandom_range(0, 10));
      sew = 3'($urandom_range(0, 3));
      tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL b2b_ready%0d got=%b want=1", t, ready_o); end
      run_op(op, sew, 1'($urandom), $urandom_range(0, 16), rnd_vec(), rnd_vec(), rnd_vec(),
             $urandom, res, ill, lat);
      e = exp_q.pop_front();
      tests++; if (res !== e.res || ill !== e.ill || lat !== e.lat) begin
        fails++; $display("FAIL b2b_%0d op=%0d sew=%0d got res=%h ill=%b lat=%0d want res=%h ill=%b lat=%0d",
                          t, op, sew, res, ill, lat, e.res, e.ill, e.lat);
      end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_kill_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
